// File: rtl/pcie_msg_queue_drain_sched.sv
// pcie_msg_queue_drain_sched
// Round-robin drain scheduler for the PCIe message SRAM. It picks one pending
// queue at a time, reads its message out over the shared AXI AR/R port in
// bursts that never cross a 4 KB page, sinks the returned beats, and then
// pulses the queue's interrupt-clear bit.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_enable            scheduler enable, looked at only while idle
//   i_intr_status       per-queue message-pending bits
//   i_q_init_addr       per-queue base byte address, ADDR_W bits per queue
//   i_q_beats           per-queue message length in beats, 7 bits per queue
//   o_intr_clear        one-hot, one-cycle clear pulse
//   o_ar*, i_arready    AXI read address channel
//   i_rvalid, i_rlast,
//   i_rresp, o_rready   AXI read data channel (data itself is discarded)
//   o_busy              scheduler not idle
//   o_cur_q             queue currently granted
//   o_err_cnt           saturating count of bad responses / misplaced rlast
//
// state | meaning
// IDLE  | waiting for enable and a pending queue; arbitration happens here
// AR    | AR request held until accepted
// R     | sinking the beats of the current burst
// CLR   | one-cycle interrupt-clear pulse for the granted queue
// WAIT  | one cycle for the pending bit to drop before arbitrating again
module pcie_msg_queue_drain_sched #(
  parameter int NUM_Q      = 15,
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic [NUM_Q-1:0]        i_intr_status,
  input  logic [NUM_Q*ADDR_W-1:0] i_q_init_addr,
  input  logic [NUM_Q*7-1:0]      i_q_beats,
  output logic [NUM_Q-1:0]        o_intr_clear,
  output logic                    o_arvalid,
  output logic [ADDR_W-1:0]       o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  input  logic                    i_arready,
  input  logic                    i_rvalid,
  input  logic                    i_rlast,
  input  logic [1:0]              i_rresp,
  output logic                    o_rready,
  output logic                    o_busy,
  output logic [3:0]              o_cur_q,
  output logic [7:0]              o_err_cnt
);

  localparam int SIZE_LOG = $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_CLR, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          last_q_q, last_q_d;
  logic [3:0]          cur_q_q, cur_q_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [6:0]          rem_q, rem_d;
  logic [6:0]          cnt_q, cnt_d;
  logic                rlast_err_q, rlast_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic                rready_q, rready_d;
  logic [NUM_Q-1:0]    intr_clear_q, intr_clear_d;
  logic                busy_q, busy_d;

  logic                found;
  int                  pick;
  logic [6:0]          beats_cur;
  logic                last_beat;
  logic                early_last;
  logic [1:0]          err_inc;
  logic [8:0]          err_sum;

  // Beats that fit before the next 4 KB page, capped by what is left.
  function automatic logic [6:0] burst_beats(input logic [ADDR_W-1:0] a,
                                             input logic [6:0] r);
    logic [12:0] room;
    room = (13'd4096 - {1'b0, a[11:0]}) >> SIZE_LOG;
    burst_beats = ({6'd0, r} < room) ? r : room[6:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    last_q_d    = last_q_q;
    cur_q_d     = cur_q_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    rlast_err_d = rlast_err_q;
    err_cnt_d   = err_cnt_q;
    found       = 1'b0;
    pick        = 0;
    beats_cur   = burst_beats(addr_q, rem_q);
    last_beat   = (cnt_q == beats_cur - 7'd1);
    early_last  = i_rlast && !last_beat && !rlast_err_q;
    err_inc     = {1'b0, (i_rresp != 2'b00)} + {1'b0, early_last};
    err_sum     = {1'b0, err_cnt_q} + {7'd0, err_inc};

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          // Search upward from the queue after the last one served.
          for (int i = 1; i <= NUM_Q; i++) begin
            if (!found && i_intr_status[(int'(last_q_q) + i) % NUM_Q]) begin
              found = 1'b1;
              pick  = (int'(last_q_q) + i) % NUM_Q;
            end
          end
        end
        if (found) begin
          cur_q_d     = 4'(pick);
          addr_d      = i_q_init_addr[pick*ADDR_W +: ADDR_W] & ~ADDR_W'(BEAT_BYTES - 1);
          rem_d       = i_q_beats[pick*7 +: 7];
          cnt_d       = 7'd0;
          rlast_err_d = 1'b0;
          state_d     = (rem_d == 7'd0) ? ST_CLR : ST_AR;
        end
      end
      ST_AR: begin
        if (i_arready) state_d = ST_R;
      end
      ST_R: begin
        // rready is always high here, so rvalid alone is a handshake.
        if (i_rvalid) begin
          err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
          if (early_last) rlast_err_d = 1'b1;
          if (last_beat) begin
            addr_d      = addr_q + (ADDR_W'(beats_cur) << SIZE_LOG);
            rem_d       = rem_q - beats_cur;
            cnt_d       = 7'd0;
            rlast_err_d = 1'b0;
            state_d     = (rem_d != 7'd0) ? ST_AR : ST_CLR;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_CLR: begin
        last_q_d = cur_q_q;
        state_d  = ST_WAIT;
      end
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with
    // the state they belong to.
    arvalid_d    = (state_d == ST_AR);
    araddr_d     = arvalid_d ? addr_d : '0;
    arlen_d      = arvalid_d ? ({1'b0, burst_beats(addr_d, rem_d)} - 8'd1) : 8'd0;
    arsize_d     = arvalid_d ? 3'(SIZE_LOG) : 3'd0;
    arburst_d    = arvalid_d ? 2'b01 : 2'b00;
    rready_d     = (state_d == ST_R);
    intr_clear_d = (state_d == ST_CLR) ? (NUM_Q'(1) << cur_q_d) : '0;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q_q     <= 4'(NUM_Q - 1);
      cur_q_q      <= 4'd0;
      addr_q       <= '0;
      rem_q        <= 7'd0;
      cnt_q        <= 7'd0;
      rlast_err_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= 8'd0;
      arsize_q     <= 3'd0;
      arburst_q    <= 2'b00;
      rready_q     <= 1'b0;
      intr_clear_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q_q     <= last_q_d;
      cur_q_q      <= cur_q_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      rlast_err_q  <= rlast_err_d;
      err_cnt_q    <= err_cnt_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      rready_q     <= rready_d;
      intr_clear_q <= intr_clear_d;
      busy_q       <= busy_d;
    end
  end

  assign o_intr_clear = intr_clear_q;
  assign o_arvalid    = arvalid_q;
  assign o_araddr     = araddr_q;
  assign o_arlen      = arlen_q;
  assign o_arsize     = arsize_q;
  assign o_arburst    = arburst_q;
  assign o_rready     = rready_q;
  assign o_busy       = busy_q;
  assign o_cur_q      = cur_q_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pcie_msg_queue_drain_sched.sv
// Directed bench for pcie_msg_queue_drain_sched. Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_pcie_msg_queue_drain_sched;
  localparam int NUM_Q  = 15;
  localparam int ADDR_W = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    i_enable;
  logic [NUM_Q-1:0]        i_intr_status;
  logic [NUM_Q*ADDR_W-1:0] i_q_init_addr;
  logic [NUM_Q*7-1:0]      i_q_beats;
  logic [NUM_Q-1:0]        o_intr_clear;
  logic                    o_arvalid;
  logic [ADDR_W-1:0]       o_araddr;
  logic [7:0]              o_arlen;
  logic [2:0]              o_arsize;
  logic [1:0]              o_arburst;
  logic                    i_arready;
  logic                    i_rvalid;
  logic                    i_rlast;
  logic [1:0]              i_rresp;
  logic                    o_rready;
  logic                    o_busy;
  logic [3:0]              o_cur_q;
  logic [7:0]              o_err_cnt;

  int passed = 0;
  int total  = 0;

  pcie_msg_queue_drain_sched #(.NUM_Q(NUM_Q), .ADDR_W(ADDR_W), .BEAT_BYTES(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_intr_status(i_intr_status),
    .i_q_init_addr(i_q_init_addr), .i_q_beats(i_q_beats), .o_intr_clear(o_intr_clear),
    .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
    .i_rresp(i_rresp), .o_rready(o_rready), .o_busy(o_busy), .o_cur_q(o_cur_q),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_q(input int q, input logic [31:0] addr, input logic [6:0] beats);
    i_q_init_addr[q*ADDR_W +: ADDR_W] = addr;
    i_q_beats[q*7 +: 7] = beats;
  endtask

  task automatic wait_arvalid();
    for (int c = 0; c < 40 && !o_arvalid; c++) @(negedge clk);
    check("arvalid_wait", o_arvalid, 1);
  endtask

  task automatic do_ar(input int q, input logic [31:0] addr, input logic [7:0] len);
    wait_arvalid();
    check("cur_q", o_cur_q, q);
    check("araddr", o_araddr, addr);
    check("arlen", o_arlen, len);
    check("arsize", o_arsize, 3'd5);
    check("arburst", o_arburst, 2'b01);
    i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0;
    check("arvalid_drop", o_arvalid, 0);
  endtask

  task automatic do_r(input int n, input int resp_k, input int last_k);
    for (int k = 0; k < n; k++) begin
      check("rready", o_rready, 1);
      i_rvalid = 1'b1;
      i_rresp  = (k == resp_k) ? 2'b10 : 2'b00;
      i_rlast  = (k == last_k);
      @(negedge clk);
    end
    i_rvalid = 1'b0;
    i_rresp  = 2'b00;
    i_rlast  = 1'b0;
  endtask

  task automatic expect_clear(input int q);
    check("clear_pulse", o_intr_clear, 15'(1) << q);
    check("clear_rready", o_rready, 0);
    check("clear_arvalid", o_arvalid, 0);
    @(negedge clk);
    check("clear_one_cycle", o_intr_clear, 0);
    check("wait_busy", o_busy, 1);
    @(negedge clk);
    check("idle_busy", o_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_intr_status = '0; i_q_init_addr = '0;
    i_q_beats = '0; i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_arvalid", o_arvalid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_clear", o_intr_clear, 0);
    check("rst_cur_q", o_cur_q, 0);
    check("rst_err", o_err_cnt, 0);
    check("rst_arsize", o_arsize, 0);
    rst_n = 1'b1;

    // Enable low: pending status must be ignored.
    i_intr_status = 15'h0001;
    repeat (3) @(negedge clk);
    check("disabled_busy", o_busy, 0);
    i_intr_status = '0;

    // Round robin, status 0x4005 held; first search starts at queue 0.
    set_q(0, 32'h0000_1000, 7'd1);
    set_q(2, 32'h0000_2040, 7'd1);
    set_q(14, 32'hABCD_EF7F, 7'd1);
    i_enable = 1'b1;
    i_intr_status = 15'h4005;
    do_ar(0, 32'h0000_1000, 8'd0); do_r(1, -1, 0); expect_clear(0);
    do_ar(2, 32'h0000_2040, 8'd0); do_r(1, -1, 0); expect_clear(2);
    do_ar(14, 32'hABCD_EF60, 8'd0); do_r(1, -1, 0); expect_clear(14);
    do_ar(0, 32'h0000_1000, 8'd0); do_r(1, -1, 0); expect_clear(0);
    i_intr_status = '0;

    // Single queue, 4 beats; AR must rise exactly one cycle after grant.
    set_q(0, 32'h0000_0000, 7'd4);
    i_intr_status = 15'h0001;
    @(negedge clk);
    check("t1_arvalid_rise", o_arvalid, 1);
    check("t1_busy", o_busy, 1);
    do_ar(0, 32'h0, 8'd3); do_r(4, -1, 3); expect_clear(0);
    i_intr_status = '0;

    // Empty queue: clear one cycle after grant, no AR.
    set_q(6, 32'h0000_0600, 7'd0);
    i_intr_status = 15'h0040;
    @(negedge clk);
    expect_clear(6);
    i_intr_status = '0;

    // 4 KB split: 0xF80 x8 -> two bursts of 4.
    set_q(3, 32'h0000_0F80, 7'd8);
    i_intr_status = 15'h0008;
    do_ar(3, 32'h0000_0F80, 8'd3); do_r(4, -1, 3);
    check("split_ar_next_cycle", o_arvalid, 1);
    check("split_no_clear", o_intr_clear, 0);
    do_ar(3, 32'h0000_1000, 8'd3); do_r(4, -1, 3); expect_clear(3);
    i_intr_status = '0;

    // AR backpressure: fields stay stable for 10 cycles.
    set_q(1, 32'h0000_0100, 7'd2);
    i_intr_status = 15'h0002;
    wait_arvalid();
    for (int c = 0; c < 10; c++) begin
      check("stall_arvalid", o_arvalid, 1);
      check("stall_araddr", o_araddr, 32'h100);
      check("stall_arlen", o_arlen, 8'd1);
      @(negedge clk);
    end
    do_ar(1, 32'h0000_0100, 8'd1); do_r(2, -1, 1); expect_clear(1);
    i_intr_status = '0;

    // Error counting and saturation: 2 errors per burst, 130 bursts.
    set_q(4, 32'h0000_0200, 7'd4);
    i_intr_status = 15'h0010;
    for (int b = 1; b <= 130; b++) begin
      do_ar(4, 32'h0000_0200, 8'd3); do_r(4, 1, 2); expect_clear(4);
      if (b == 1)   check("err_first", o_err_cnt, 8'd2);
      if (b == 127) check("err_254", o_err_cnt, 8'd254);
      if (b == 128) check("err_sat", o_err_cnt, 8'd255);
    end
    check("err_held_sat", o_err_cnt, 8'd255);
    i_intr_status = '0;

    // Reset in the middle of queue 5's R phase.
    set_q(5, 32'h0000_0500, 7'd4);
    set_q(9, 32'h0000_0900, 7'd1);
    i_intr_status = 15'h0220;
    do_ar(5, 32'h0000_0500, 8'd3);
    i_rvalid = 1'b1;
    @(negedge clk);
    i_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_arvalid", o_arvalid, 0);
    check("mid_rst_rready", o_rready, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_clear", o_intr_clear, 0);
    check("mid_rst_err", o_err_cnt, 0);
    check("mid_rst_cur_q", o_cur_q, 0);
    check("mid_rst_araddr", o_araddr, 0);
    @(negedge clk);
    check("mid_rst_no_clear", o_intr_clear, 0);
    rst_n = 1'b1;
    do_ar(5, 32'h0000_0500, 8'd3); do_r(4, -1, 3); expect_clear(5);
    i_intr_status = 15'h0200;
    do_ar(9, 32'h0000_0900, 8'd0); do_r(1, -1, 0); expect_clear(9);
    i_intr_status = '0;
    repeat (2) @(negedge clk);
    check("final_idle", o_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
